yonga_lz4_src_arbiter: RTL and testbench
========================================

// Module: yonga_lz4_src_arbiter
// PURPOSE
// - Shares the single compressed-byte input of the LZ4 decoder among NUM_SRC byte-stream requesters
//   (Wishbone write path, UART RX FIFO, logic-analyzer port).
// - Round-robin grant, locked for a whole frame (until src_last handshake) so frames never interleave.
// - Idle-timeout watchdog releases a stalled owner; sits between the source adapters and the decoder core.
// PARAMETERS
// - NUM_SRC    3   number of requesters (index 0 = WB, 1 = UART, 2 = LA)
// - DATA_W     8   byte-stream width
// - TMO_W      16  width of timeout counter / timeout_cycles input
// PORTS
// - clk            in   1                 system clock (single domain)
// - rst            in   1                 synchronous, active-high reset
// - src_valid      in   NUM_SRC           per-source byte valid
// - src_data       in   NUM_SRC*DATA_W    per-source byte, source i at [i*DATA_W +: DATA_W]
// - src_last       in   NUM_SRC           per-source last byte of frame
// - src_ready      out  NUM_SRC           per-source accept
// - dec_valid      out  1                 byte valid to decoder
// - dec_data       out  DATA_W            byte to decoder
// - dec_last       out  1                 end of frame to decoder
// - dec_ready      in   1                 decoder accept
// - timeout_cycles in   TMO_W             idle limit while locked; 0 disables watchdog
// - grant_id       out  2                 current owner index (valid when busy)
// - busy           out  1                 1 while a source holds the lock
// - dec_abort      out  1                 1-cycle pulse: frame aborted by timeout (decoder must discard)
// BEHAVIOUR
// - Reset: state=IDLE, grant_id=0, rr_ptr=0 (WB highest priority first), busy=0, dec_abort=0,
//   tmo_cnt=0; all src_ready=0, dec_valid=0, dec_last=0 (dec_data don't-care, driven 0).
// - FSM IDLE -> LOCK -> IDLE.
// - IDLE: src_ready=0, dec_valid=0. If any src_valid, pick first requester at/after rr_ptr (rotating
//   priority); register grant_id, busy=1, go LOCK. Grant visible next cycle; no data transferred in IDLE.
// - LOCK: combinational pass-through of granted source: dec_valid=src_valid[g], dec_data=src_data[g],
//   dec_last=src_last[g], src_ready[g]=dec_ready; all other src_ready=0. Zero added latency.
// - Handshake = dec_valid & dec_ready. On handshake with dec_last: next state IDLE, busy=0,
//   rr_ptr=(g+1) mod NUM_SRC. Consequently exactly one dead cycle between consecutive frames.
// - Watchdog: in LOCK, tmo_cnt clears on any cycle with src_valid[g]=1, else increments (saturating).
//   When timeout_cycles!=0 and tmo_cnt reaches timeout_cycles-1 with src_valid[g]=0: pulse dec_abort,
//   go IDLE, rr_ptr=(g+1) mod NUM_SRC. Decoder stall (valid=1, ready=0) never times out.
// - Simultaneous last-handshake and timeout condition impossible (last needs valid=1); handshake wins.
// - Requests arriving on non-granted sources while locked are held off (ready=0), not dropped.
// - timeout_cycles sampled every cycle; changing it mid-frame takes effect immediately.
// - rr_ptr wraps NUM_SRC-1 -> 0. rst mid-frame: immediate return to reset values; partial frame lost,
//   no dec_abort pulse (decoder is reset by the same rst).
// - Sources must hold data/last stable while valid & !ready (standard valid/ready rules).
// STRUCTURE
// - Package yonga_lz4_pkg: SRC_WB=0, SRC_UART=1, SRC_LA=2, NUM_SRC, state enum {ST_IDLE, ST_LOCK}.
// - Sub-module yonga_rr_pick: combinational rotating-priority encoder (req, ptr -> gnt_idx, gnt_any).
// - Top holds FSM, grant/rr_ptr/tmo_cnt registers and the output mux.
// TESTING
// - Single source: UART sends 4-byte frame 0x11,0x22,0x33,0x44(last), dec_ready=1 -> grant next cycle,
//   4 bytes out in 4 consecutive cycles, busy drops cycle after last.
// - Contention: all three valid at once after reset -> order WB, UART, LA frames, one idle cycle
//   between each; no byte from another source appears mid-frame.
// - Back-pressure: dec_ready toggles 1/0 during WB frame -> data held stable, no loss/dup, no timeout
//   with timeout_cycles=3.
// - Timeout: LA sends 2 bytes then stops, timeout_cycles=5 -> dec_abort pulses exactly once, 5 cycles
//   after last valid; next grant goes to WB (rr_ptr wrap).
// - timeout_cycles=0, UART idle 1000 cycles mid-frame -> lock held, no abort, frame completes later.
// - rst asserted mid-frame of UART -> next cycle all outputs at reset values; next arbitration
//   starts from WB.

Source files
------------

// File: rtl/yonga_lz4_pkg.sv
// rtl/yonga_lz4_pkg.sv - shared constants and types for the LZ4 source arbiter
package yonga_lz4_pkg;

    localparam int NUM_SRC  = 3;
    localparam int SRC_WB   = 0;
    localparam int SRC_UART = 1;
    localparam int SRC_LA   = 2;
    localparam int IDX_W    = 2;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    // Round-robin successor of a source index, wrapping NUM_SRC-1 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_SRC - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/yonga_rr_pick.sv
// rtl/yonga_rr_pick.sv - rotating-priority encoder: first requester at or after ptr
module yonga_rr_pick
    import yonga_lz4_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    int idx;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        idx     = 0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_SRC;
            if (req[idx]) begin
                gnt_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/yonga_lz4_src_arbiter.sv
// rtl/yonga_lz4_src_arbiter.sv - frame-locked round-robin arbiter feeding the LZ4 decoder byte input
module yonga_lz4_src_arbiter
    import yonga_lz4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TMO_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        dec_valid,
    output logic [DATA_W-1:0]           dec_data,
    output logic                        dec_last,
    input  logic                        dec_ready,
    input  logic [TMO_W-1:0]            timeout_cycles,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        dec_abort
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant_q, grant_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic               g_valid, g_last, tmo_hit;
    logic [DATA_W-1:0]  g_data;

    yonga_rr_pick u_pick (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign g_valid = src_valid[grant_q];
    assign g_last  = src_last[grant_q];
    assign g_data  = src_data[int'(grant_q)*DATA_W +: DATA_W];

    // tmo_cnt holds the quiet cycles already seen; this cycle is the next one.
    assign tmo_hit = (timeout_cycles != '0) && !g_valid &&
                     (tmo_cnt >= timeout_cycles - TMO_W'(1));

    assign busy     = (state == ST_LOCK);
    assign grant_id = grant_q;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        rr_nxt    = rr_ptr;
        tmo_nxt   = '0;
        src_ready = '0;
        dec_valid = 1'b0;
        dec_data  = '0;
        dec_last  = 1'b0;
        dec_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_LOCK;
                    grant_nxt = pick_idx;
                end
            end
            ST_LOCK: begin
                dec_valid          = g_valid;
                dec_data           = g_data;
                dec_last           = g_last;
                src_ready[grant_q] = dec_ready;
                if (g_valid && dec_ready && g_last) begin
                    state_nxt = ST_IDLE;
                    rr_nxt    = next_idx(grant_q);
                end else if (tmo_hit) begin
                    // The decoder shares rst, so no abort is signalled while reset is applied.
                    dec_abort = !rst;
                    state_nxt = ST_IDLE;
                    rr_nxt    = next_idx(grant_q);
                end else if (!g_valid) begin
                    tmo_nxt = (&tmo_cnt) ? tmo_cnt : tmo_cnt + TMO_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_yonga_lz4_src_arbiter.sv
// tb/tb_yonga_lz4_src_arbiter.sv - randomized and directed bench for yonga_lz4_src_arbiter
module tb_yonga_lz4_src_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid, src_last, src_ready;
    logic [N*DW-1:0] src_data;
    logic            dec_valid, dec_last, dec_ready, busy, dec_abort;
    logic [DW-1:0]   dec_data;
    logic [TW-1:0]   timeout_cycles;
    logic [1:0]      grant_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    yonga_lz4_src_arbiter #(.DATA_W(DW), .TMO_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_last       (src_last),
        .src_ready      (src_ready),
        .dec_valid      (dec_valid),
        .dec_data       (dec_data),
        .dec_last       (dec_last),
        .dec_ready      (dec_ready),
        .timeout_cycles (timeout_cycles),
        .grant_id       (grant_id),
        .busy           (busy),
        .dec_abort      (dec_abort)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source stimulus: each queue entry is {last, data}.
    logic [8:0] q [N][$];
    int         en_pct [N];
    int         rdy_mode;
    logic [N-1:0] hs_seen = '0;

    // Reference model: owner of the lock (-1 idle), rotating pointer, run of quiet cycles.
    int   m_owner = -1;
    int   m_rr = 0;
    int   m_quiet = 0;
    bit   armed = 0;
    int   cyc = 0, aborts = 0, last_v_cyc = 0, abort_cyc = 0;
    int   log_src [$];
    logic [8:0] log_byte [$];

    always @(negedge clk) begin : cmp
        logic [N-1:0] ev_ready;
        logic         ev_valid, ev_last, ev_abort, gv;
        logic [DW-1:0] ev_data;
        int           g, pick;
        cyc++;
        ev_ready = '0; ev_valid = 0; ev_last = 0; ev_abort = 0; ev_data = '0; gv = 0; g = 0;
        if (m_owner >= 0) begin
            g        = m_owner;
            gv       = src_valid[g];
            ev_valid = gv;
            ev_data  = src_data[g*DW +: DW];
            ev_last  = src_last[g];
            ev_ready[g] = dec_ready;
            ev_abort = !rst && (timeout_cycles != 0) && !gv && (m_quiet + 1 >= int'(timeout_cycles));
        end
        if (armed) begin
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("src_ready", 32'(src_ready), 32'(ev_ready));
            chk("dec_valid", 32'(dec_valid), 32'(ev_valid));
            chk("dec_abort", 32'(dec_abort), 32'(ev_abort));
            if (ev_valid) begin
                chk("dec_data", 32'(dec_data), 32'(ev_data));
                chk("dec_last", 32'(dec_last), 32'(ev_last));
            end
            if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
        end
        if (dec_valid && dec_ready) begin
            log_src.push_back(m_owner);
            log_byte.push_back({dec_last, dec_data});
        end
        if (dec_abort) begin
            aborts++;
            abort_cyc = cyc;
        end
        if (m_owner >= 0 && gv) last_v_cyc = cyc;
        hs_seen = src_valid & src_ready;

        if (rst) begin
            m_owner = -1; m_rr = 0; m_quiet = 0; armed = 1;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && src_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
            if (pick >= 0) begin
                m_owner = pick; m_quiet = 0;
            end
        end else if (ev_valid && dec_ready && ev_last) begin
            m_rr = (m_owner + 1) % N; m_owner = -1;
        end else if (ev_abort) begin
            m_rr = (m_owner + 1) % N; m_owner = -1;
        end else begin
            m_quiet = gv ? 0 : m_quiet + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++) begin
            if (hs_seen[s]) begin
                if (q[s].size() > 0) void'(q[s].pop_front());
                src_valid[s] = 1'b0;
            end
            if (!src_valid[s] && q[s].size() > 0 && int'($urandom_range(99)) < en_pct[s]) begin
                src_valid[s]          = 1'b1;
                src_data[s*DW +: DW]  = q[s][0][7:0];
                src_last[s]           = q[s][0][8];
            end
        end
        case (rdy_mode)
            0:       dec_ready = 1'($urandom_range(1));
            2:       dec_ready = ~dec_ready;
            default: dec_ready = 1'b1;
        endcase
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int s = 0; s < N; s++) q[s].delete();
        src_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_frame(input int s, input int n, input int first, input int step, input bit with_last);
        for (int i = 0; i < n; i++)
            q[s].push_back({1'(with_last && i == n - 1), 8'(first + i * step)});
    endtask

    task automatic run_until_idle(input int max);
        int i = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && !busy) && i < max) begin
            tick();
            i++;
        end
        chk("drain_in_budget", 32'(i < max), 32'd1);
    endtask

    initial begin
        int a0, lsz, ord [8];
        rst = 1'b1; src_valid = '0; src_last = '0; src_data = '0; dec_ready = 1'b0;
        timeout_cycles = '0; rdy_mode = 1;
        for (int s = 0; s < N; s++) en_pct[s] = 100;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_dec_last", 32'(dec_last), 0);
        chk("rst_dec_abort", 32'(dec_abort), 0);

        // UART single frame: grant next cycle, four back-to-back bytes, busy drops after last.
        log_src.delete(); log_byte.delete();
        push_frame(1, 4, 8'h11, 8'h11, 1);
        tick();
        chk("uart_idle_no_data", 32'(dec_valid), 0);
        chk("uart_idle_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("uart_busy", 32'(busy), 1);
            chk("uart_grant", 32'(grant_id), 1);
            chk("uart_byte", 32'({dec_valid, dec_last, dec_data}), 32'({1'b1, 1'(i == 3), 8'((i + 1) * 8'h11)}));
        end
        tick();
        chk("uart_busy_drop", 32'(busy), 0);
        chk("uart_count", 32'(log_byte.size()), 4);

        // Contention from reset: WB, UART, LA in order with whole frames.
        do_reset();
        log_src.delete(); log_byte.delete();
        push_frame(0, 3, 8'hA0, 1, 1);
        push_frame(1, 2, 8'hB0, 1, 1);
        push_frame(2, 3, 8'hC0, 1, 1);
        run_until_idle(200);
        ord = '{0, 0, 0, 1, 1, 2, 2, 2};
        chk("cont_count", 32'(log_src.size()), 8);
        for (int i = 0; i < 8 && i < log_src.size(); i++)
            chk("cont_order", 32'(log_src[i]), 32'(ord[i]));

        // Back-pressure on a WB frame with a short watchdog.
        log_src.delete(); log_byte.delete();
        timeout_cycles = 3; rdy_mode = 2; a0 = aborts;
        push_frame(0, 6, 8'h50, 3, 1);
        run_until_idle(200);
        chk("bp_no_abort", 32'(aborts - a0), 0);
        chk("bp_count", 32'(log_byte.size()), 6);
        for (int i = 0; i < 6 && i < log_byte.size(); i++)
            chk("bp_byte", 32'(log_byte[i]), 32'({1'(i == 5), 8'(8'h50 + 3 * i)}));

        // LA stalls after two bytes: abort five cycles after its last valid, then WB next.
        rdy_mode = 1; timeout_cycles = 5; a0 = aborts;
        push_frame(2, 2, 8'h70, 1, 0);
        for (int i = 0; i < 100 && aborts == a0; i++) tick();
        repeat (10) tick();
        chk("tmo_abort_once", 32'(aborts - a0), 1);
        chk("tmo_abort_delay", 32'(abort_cyc - last_v_cyc), 5);
        push_frame(0, 1, 8'h01, 0, 1);
        push_frame(1, 1, 8'h02, 0, 1);
        tick(); tick();
        chk("tmo_next_busy", 32'(busy), 1);
        chk("tmo_next_grant_wb", 32'(grant_id), 0);
        run_until_idle(100);

        // Watchdog disabled: a UART frame idles for 1000 cycles and still completes.
        timeout_cycles = 0; a0 = aborts;
        push_frame(1, 1, 8'h33, 0, 0);
        repeat (1000) tick();
        chk("nowd_busy", 32'(busy), 1);
        chk("nowd_grant", 32'(grant_id), 1);
        chk("nowd_no_abort", 32'(aborts - a0), 0);
        push_frame(1, 1, 8'h34, 0, 1);
        run_until_idle(100);
        lsz = log_byte.size();
        chk("nowd_last_byte", 32'(log_byte[lsz - 1]), 32'({1'b1, 8'h34}));
        chk("nowd_no_abort_end", 32'(aborts - a0), 0);

        // Reset mid-frame of UART (pointer sits at LA), then arbitration restarts at WB.
        push_frame(1, 8, 8'h90, 1, 1);
        repeat (4) tick();
        chk("rstmid_pre_busy", 32'(busy), 1);
        a0 = aborts;
        timeout_cycles = 1;
        do_reset();
        timeout_cycles = 0;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_grant", 32'(grant_id), 0);
        chk("rstmid_dec_valid", 32'(dec_valid), 0);
        chk("rstmid_src_ready", 32'(src_ready), 0);
        chk("rstmid_no_abort", 32'(aborts - a0), 0);
        push_frame(0, 1, 8'hE0, 0, 1);
        push_frame(1, 1, 8'hE1, 0, 1);
        push_frame(2, 1, 8'hE2, 0, 1);
        tick(); tick();
        chk("rstmid_first_wb", 32'(grant_id), 0);
        run_until_idle(100);

        // Randomized traffic, gaps and back-pressure; the model checks every cycle.
        do_reset();
        rdy_mode = 0;
        timeout_cycles = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(8, 2));
        for (int s = 0; s < N; s++) en_pct[s] = int'($urandom_range(100, 30));
        for (int c = 0; c < 2500; c++) begin
            for (int s = 0; s < N; s++)
                if ($urandom_range(15) == 0 && q[s].size() < 20)
                    push_frame(s, int'($urandom_range(6, 1)), int'($urandom_range(255)), int'($urandom_range(7)), 1);
            tick();
        end
        for (int s = 0; s < N; s++) en_pct[s] = 100;
        rdy_mode = 1;
        push_frame(0, 1, 8'hFF, 0, 1);
        push_frame(1, 1, 8'hFF, 0, 1);
        push_frame(2, 1, 8'hFF, 0, 1);
        run_until_idle(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
